// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// State encoding and index-width derivation used by rr_hold_arbiter.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

   // Width of a binary requester index; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_hold_arbiter_prio.sv
// Fixed-priority arbiter: the lowest set request index wins, result is one-hot.
// Pure combinational; used twice by rr_hold_arbiter (masked and unmasked requests).
module priority_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o
);

   // Two's-complement trick isolates the lowest set bit.
   assign gnt_o = req_i & (~req_i + N'(1));

endmodule

// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter that holds a grant until done or request drop.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_hold_arbiter
   import arb_pkg::*;
#(
   parameter int INPUTS   = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [INPUTS-1:0]           req,
   input  logic [INPUTS-1:0]           done,
   output logic [INPUTS-1:0]           grant,
   output logic [idx_w(INPUTS)-1:0]    grant_idx,
   output logic                        busy,
   output logic                        timeout
);

   localparam int IDX_W = idx_w(INPUTS);

   if (INPUTS < 2 || MAX_HOLD < 1) begin : g_bad_cfg
      $error("rr_hold_arbiter: INPUTS must be >= 2 and MAX_HOLD >= 1");
   end

   arb_state_e        state_q;
   logic [INPUTS-1:0] grant_q;
   logic [IDX_W-1:0]  grant_idx_q;
   logic [IDX_W-1:0]  last_idx_q;
   logic              busy_q;

   logic [INPUTS-1:0] mask;
   logic [INPUTS-1:0] req_masked;
   logic [INPUTS-1:0] gnt_masked;
   logic [INPUTS-1:0] gnt_plain;
   logic [INPUTS-1:0] winner_oh;
   logic [IDX_W-1:0]  winner_idx;
   logic              owner_release;
   logic              hold_limit;

   // Rotating priority: only indices strictly above the last owner get first pick.
   always_comb begin
      mask = '0;
      for (int i = 0; i < INPUTS; i++) begin
         mask[i] = (IDX_W'(i) > last_idx_q);
      end
   end

   assign req_masked = req & mask;

   priority_arbiter #(.N(INPUTS)) u_prio_masked (
      .req_i (req_masked),
      .gnt_o (gnt_masked)
   );

   priority_arbiter #(.N(INPUTS)) u_prio_plain (
      .req_i (req),
      .gnt_o (gnt_plain)
   );

   assign winner_oh = (|gnt_masked) ? gnt_masked : gnt_plain;

   always_comb begin
      winner_idx = '0;
      for (int i = 0; i < INPUTS; i++) begin
         if (winner_oh[i]) begin
            winner_idx = winner_idx | IDX_W'(i);
         end
      end
   end

   assign owner_release = done[grant_idx_q] | ~req[grant_idx_q];

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD + 1);

   logic [CNT_W-1:0] hold_cnt_q;
   logic             timeout_q;

   // Limit hits in the MAX_HOLD-th owned cycle, so the grant lasts exactly MAX_HOLD cycles.
   assign hold_limit = (state_q == OWNED) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
   assign timeout    = timeout_q;
`else
   assign hold_limit = 1'b0;
   assign timeout    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         grant_idx_q <= '0;
         busy_q      <= 1'b0;
         last_idx_q  <= IDX_W'(INPUTS - 1);
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q  <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
               hold_cnt_q <= '0;
`endif
               if (|req) begin
                  state_q     <= OWNED;
                  grant_q     <= winner_oh;
                  grant_idx_q <= winner_idx;
                  busy_q      <= 1'b1;
                  last_idx_q  <= winner_idx;
               end
            end
            OWNED: begin
`ifdef ARB_TIMEOUT_EN
               hold_cnt_q <= hold_cnt_q + CNT_W'(1);
`endif
               // A normal release wins over a coincident hold limit, so no timeout pulse then.
               if (owner_release || hold_limit) begin
                  state_q     <= IDLE;
                  grant_q     <= '0;
                  grant_idx_q <= '0;
                  busy_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                  timeout_q   <= ~owner_release;
`endif
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign grant     = grant_q;
   assign grant_idx = grant_idx_q;
   assign busy      = busy_q;

endmodule
